// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen geometry, the transparent palette index and the
// pixel-coordinate / palette-index types used by the sprite fetch slice.
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [9:0] coord_t;
   typedef logic [3:0] pal_idx_t;

   localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/anim_frame_seq.sv
// anim_frame_seq: vsync-driven animation frame sequencer.
// Every vsync falling edge is one tick. While anim_en is high each tick bumps
// a hold counter; after HOLD_FRAMES ticks the frame select advances, wrapping
// from NUM_FRAMES-1 back to 0. frame_sel only moves on a tick, i.e. during
// vertical blanking, so a visible frame never mixes two sprite frames.
//
// Ports:
//   Clk       pixel clock
//   Reset     synchronous active-high reset
//   vsync     VGA vsync (active low)
//   anim_en   1 = animation advances on ticks
//   frame_sel current animation frame
module anim_frame_seq #(
   parameter  int NUM_FRAMES  = 3,
   parameter  int HOLD_FRAMES = 8,
   localparam int FS_W        = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1,
   localparam int HC_W        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            vsync,
   input  logic            anim_en,
   output logic [FS_W-1:0] frame_sel
);

   logic            vsync_prev;
   logic [HC_W-1:0] hold_cnt;
   logic            tick;

   // Falling edge only: a long low vsync pulse counts once.
   assign tick = vsync_prev && !vsync;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vsync_prev <= 1'b1;
         hold_cnt   <= '0;
         frame_sel  <= '0;
      end else begin
         vsync_prev <= vsync;
         if (tick && anim_en) begin
            if (hold_cnt == HC_W'(HOLD_FRAMES - 1)) begin
               hold_cnt <= '0;
               if (frame_sel == FS_W'(NUM_FRAMES - 1))
                  frame_sel <= '0;
               else
                  frame_sel <= frame_sel + 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sprite_index_fetch.sv
// sprite_index_fetch: addresses the sprite index ROM from the scan position
// and emits a 4-bit palette index per pixel with a fixed 3-cycle latency.
//
// Ports:
//   Clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY        current scan column / row
//   active_in           1 = visible video region
//   vsync               VGA vsync (active low), drives the animation sequencer
//   sprite_x, sprite_y  sprite top-left corner
//   anim_en             1 = animation advances
//   rom_addr            registered ROM address (frame base + {oy, ox})
//   rom_q               ROM data, valid one cycle after rom_addr
//   pix_index           palette index (0 unless an opaque sprite pixel)
//   pix_hit             opaque sprite pixel
//   pix_active          active_in aligned with pix_index
//   frame_sel           current animation frame
module sprite_index_fetch
   import sprite_pkg::*;
#(
   parameter  int SPRITE_W    = 32,
   parameter  int SPRITE_H    = 32,
   parameter  int NUM_FRAMES  = 3,
   parameter  int HOLD_FRAMES = 8,
   parameter  int ADDR_W      = 12,
   localparam int FS_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              active_in,
   input  logic              vsync,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic              anim_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pix_index,
   output logic              pix_hit,
   output logic              pix_active,
   output logic [FS_W-1:0]   frame_sel
);

   localparam int OX_W = $clog2(SPRITE_W);
   localparam int OY_W = $clog2(SPRITE_H);
   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPRITE_W * SPRITE_H);

   function automatic pal_idx_t opaque_idx(input logic hit, input pal_idx_t q);
      return (hit && (q != TRANSPARENT_IDX)) ? q : TRANSPARENT_IDX;
   endfunction

   anim_frame_seq #(
      .NUM_FRAMES  (NUM_FRAMES),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_seq (
      .Clk       (Clk),
      .Reset     (Reset),
      .vsync     (vsync),
      .anim_en   (anim_en),
      .frame_sel (frame_sel)
   );

   // Stage p0: hit test and address, combinational from the scan position
   coord_t            drawx_c, drawy_c, spx_c, spy_c;
   logic [10:0]       x_end_p0, y_end_p0;
   logic              in_screen_p0, in_x_p0, in_y_p0, hit_p0;
   logic [OX_W-1:0]   ox_p0;
   logic [OY_W-1:0]   oy_p0;
   logic [ADDR_W-1:0] addr_p0;

   assign drawx_c = DrawX;
   assign drawy_c = DrawY;
   assign spx_c   = sprite_x;
   assign spy_c   = sprite_y;

   // 11-bit ends: a sprite near the right/bottom edge clips instead of wrapping.
   assign x_end_p0 = {1'b0, spx_c} + 11'(SPRITE_W);
   assign y_end_p0 = {1'b0, spy_c} + 11'(SPRITE_H);

   assign in_screen_p0 = (drawx_c < 10'(SCREEN_W)) && (drawy_c < 10'(SCREEN_H)) &&
                         (spx_c   < 10'(SCREEN_W)) && (spy_c   < 10'(SCREEN_H));
   assign in_x_p0 = (drawx_c >= spx_c) && ({1'b0, drawx_c} < x_end_p0);
   assign in_y_p0 = (drawy_c >= spy_c) && ({1'b0, drawy_c} < y_end_p0);
   assign hit_p0  = active_in && in_screen_p0 && in_x_p0 && in_y_p0;

   // Only the low bits of the offsets matter inside a hit, and the low bits of
   // a difference equal the difference of the low bits.
   assign ox_p0 = drawx_c[OX_W-1:0] - spx_c[OX_W-1:0];
   assign oy_p0 = drawy_c[OY_W-1:0] - spy_c[OY_W-1:0];

   assign addr_p0 = hit_p0 ? (ADDR_W'(frame_sel) * FRAME_SZ + ADDR_W'({oy_p0, ox_p0}))
                           : '0;

   // Stage p1: address presented to the ROM, flags delayed alongside
   logic hit_p1, vld_p1;
   // Stage p2: ROM data valid, flags aligned with it
   logic hit_p2, vld_p2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr   <= '0;
         hit_p1     <= 1'b0;
         vld_p1     <= 1'b0;
         hit_p2     <= 1'b0;
         vld_p2     <= 1'b0;
         pix_index  <= '0;
         pix_hit    <= 1'b0;
         pix_active <= 1'b0;
      end else begin
         rom_addr   <= addr_p0;
         hit_p1     <= hit_p0;
         vld_p1     <= active_in;
         hit_p2     <= hit_p1;
         vld_p2     <= vld_p1;
         // Stage p3: registered outputs
         pix_index  <= opaque_idx(hit_p2, rom_q);
         pix_hit    <= hit_p2 && (rom_q != TRANSPARENT_IDX);
         pix_active <= vld_p2;
      end
   end

endmodule

// File: tb/tb_sprite_index_fetch.sv
module tb_sprite_index_fetch;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
   logic        active_in, vsync, anim_en;
   logic [11:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  pix_index;
   logic        pix_hit, pix_active;
   logic [1:0]  frame_sel;

   logic [3:0]  rom [0:4095];
   int          total = 0;
   int          bad   = 0;

   always #5 Clk = ~Clk;

   // Synchronous ROM model: data one cycle after the address.
   always @(posedge Clk) rom_q <= rom[rom_addr];

   sprite_index_fetch dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .active_in  (active_in),
      .vsync      (vsync),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .anim_en    (anim_en),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .pix_index  (pix_index),
      .pix_hit    (pix_hit),
      .pix_active (pix_active),
      .frame_sel  (frame_sel)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive one pixel and hold it until its output emerges.
   task automatic px(input string tag, input int x, input int y, input logic act,
                     input int exp_addr, input int exp_idx, input logic exp_hit);
      DrawX = 10'(x); DrawY = 10'(y); active_in = act;
      step();
      chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
      step();
      step();
      chk({tag, ".idx"}, 32'(pix_index), 32'(exp_idx));
      chk({tag, ".hit"}, 32'(pix_hit), 32'(exp_hit));
      chk({tag, ".act"}, 32'(pix_active), 32'(act));
   endtask

   task automatic vtick();
      vsync = 1'b0; step();
      vsync = 1'b1; step();
   endtask

   initial begin
      int hits;
      for (int i = 0; i < 4096; i++) rom[i] = 4'((i * 7 + 2) % 16);
      rom[10] = 4'h0;

      // Reset with a hitting, toggling input pattern
      Reset = 1'b1; DrawX = 10'd100; DrawY = 10'd50; sprite_x = 10'd100; sprite_y = 10'd50;
      active_in = 1'b1; anim_en = 1'b1; vsync = 1'b0;
      step(); step();
      vsync = 1'b1;
      step();
      chk("rst.addr", 32'(rom_addr), 0);
      chk("rst.idx", 32'(pix_index), 0);
      chk("rst.hit", 32'(pix_hit), 0);
      chk("rst.act", 32'(pix_active), 0);
      chk("rst.frame", 32'(frame_sel), 0);
      Reset = 1'b0;
      step();
      chk("fill1.act", 32'(pix_active), 0);
      step();
      chk("fill2.act", 32'(pix_active), 0);
      chk("fill2.hit", 32'(pix_hit), 0);
      step();
      chk("fill3.act", 32'(pix_active), 1);
      chk("fill3.idx", 32'(pix_index), 2);
      chk("fill3.frame", 32'(frame_sel), 0);

      // Basic hit, miss, transparency, inactive
      px("hit00",   100, 50, 1'b1, 0,    2,  1'b1);
      px("hit1023", 131, 81, 1'b1, 1023, 11, 1'b1);
      px("missx",   99,  50, 1'b1, 0,    0,  1'b0);
      px("missy",   100, 82, 1'b1, 0,    0,  1'b0);
      px("transp",  110, 50, 1'b1, 10,   0,  1'b0);
      px("inact",   100, 50, 1'b0, 0,    0,  1'b0);

      // Clipping at the right edge
      sprite_x = 10'd620; sprite_y = 10'd0;
      px("clip639", 639, 0, 1'b1, 19, 7, 1'b1);
      px("clip0",   0,   0, 1'b1, 0,  0, 1'b0);
      sprite_x = 10'd700;
      hits = 0;
      DrawY = 10'd0; active_in = 1'b1;
      for (int x = 0; x < 640; x++) begin
         DrawX = 10'(x);
         step();
         if (rom_addr != 12'd0 || pix_hit) hits++;
      end
      chk("offscreen.sweep", 32'(hits), 0);

      // Animation
      sprite_x = 10'd100; sprite_y = 10'd50;
      repeat (8) vtick();
      chk("anim8.frame", 32'(frame_sel), 1);
      px("anim8", 100, 50, 1'b1, 1024, 2, 1'b1);
      repeat (8) vtick();
      chk("anim16.frame", 32'(frame_sel), 2);
      px("anim16", 100, 50, 1'b1, 2048, 4'((2048 * 7 + 2) % 16), 1'b1);
      repeat (8) vtick();
      chk("anim24.frame", 32'(frame_sel), 0);
      vsync = 1'b0;
      repeat (100) step();
      vsync = 1'b1;
      step();
      repeat (6) vtick();
      chk("longlow.frame", 32'(frame_sel), 0);
      vtick();
      chk("longlow8.frame", 32'(frame_sel), 1);
      anim_en = 1'b0;
      repeat (16) vtick();
      chk("animoff.frame", 32'(frame_sel), 1);
      anim_en = 1'b1;
      repeat (13) vtick();
      chk("pre_rst.frame", 32'(frame_sel), 2);

      // Reset in the middle of a hit stream
      DrawX = 10'd105; DrawY = 10'd52; active_in = 1'b1;
      step();
      chk("stream.addr", 32'(rom_addr), 2117);
      step(); step();
      chk("stream.idx", 32'(pix_index), 5);
      Reset = 1'b1;
      step();
      chk("mrst.addr", 32'(rom_addr), 0);
      chk("mrst.idx", 32'(pix_index), 0);
      chk("mrst.hit", 32'(pix_hit), 0);
      chk("mrst.act", 32'(pix_active), 0);
      chk("mrst.frame", 32'(frame_sel), 0);
      Reset = 1'b0;
      repeat (7) vtick();
      chk("post7.frame", 32'(frame_sel), 0);
      vtick();
      chk("post8.frame", 32'(frame_sel), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_index_fetch.md
Name: sprite_index_fetch

Overview:
- Upstream neighbour of the per-sprite colour palette lookup.
- Takes VGA scan coordinates and the sprite position, addresses the sprite's synchronous index ROM, and emits a 4-bit palette index per pixel, aligned with a pipelined video-active flag.
- Includes a vsync-driven animation frame sequencer that selects which sprite frame is read.
- Index 0 means transparent/background; the palette maps index 0 to the sky colour.

Parameters:
- SPRITE_W, 32, sprite width in pixels; must be a power of two.
- SPRITE_H, 32, sprite height in pixels; must be a power of two.
- NUM_FRAMES, 3, number of animation frames stored back-to-back in the ROM.
- HOLD_FRAMES, 8, vsync periods each animation frame is shown.
- ADDR_W, 12, ROM address width; must be at least clog2(NUM_FRAMES*SPRITE_W*SPRITE_H).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current scan column, 0..639.
- DrawY  in  10  current scan row, 0..479.
- active_in  in  1  1 = visible video region.
- vsync  in  1  VGA vsync, active low.
- sprite_x  in  10  sprite top-left column.
- sprite_y  in  10  sprite top-left row.
- anim_en  in  1  1 = animation advances.
- rom_addr  out  ADDR_W  registered address to the sprite ROM.
- rom_q  in  4  ROM data; valid one cycle after rom_addr.
- pix_index  out  4  palette index for the downstream palette lookup.
- pix_hit  out  1  opaque sprite pixel.
- pix_active  out  1  active_in delayed to align with pix_index.
- frame_sel  out  clog2(NUM_FRAMES)  current animation frame.

Behaviour:
- Reset (synchronous): rom_addr, pix_index, pix_hit, pix_active, frame_sel, hold counter and all pipeline registers go to 0; the vsync history register goes to 1. The value holds while Reset is high; a reset mid-frame flushes the pipeline.
- Hit test, cycle N, combinational:
  - hit0 = active_in && DrawX >= sprite_x && DrawX < sprite_x+SPRITE_W, with the same test on Y against SPRITE_H.
  - Sums are computed 11 bits wide, so there is no wrap.
- Address: ox = DrawX-sprite_x, oy = DrawY-sprite_y, addr = frame_sel*SPRITE_W*SPRITE_H + oy*SPRITE_W + ox. The within-frame part is a concatenation {oy, ox}.
  - rom_addr is registered at the end of N (visible in N+1).
  - rom_addr = 0 when hit0 = 0.
- rom_q is valid in N+2. hit0 and active_in travel through 2 delay stages alongside it.
- Output registers update at the end of N+2 (visible in N+3), giving a fixed 3-cycle latency for all three outputs:
  - pix_hit = hit_d2 && (rom_q != TRANSPARENT_IDX).
  - pix_index = pix_hit ? rom_q : 0.
  - pix_active = active_d2.
- Edge clipping:
  - A sprite extending past column 639 or row 479 is clipped; it never wraps to column or row 0.
  - sprite_x >= 640 or sprite_y >= 480 never hits.
- Sprite position changes mid-frame take effect on the next sampled pixel. There is no latching.
- Frame sequencer:
  - The vsync falling edge (prev=1, cur=0) is the tick; vsync held low counts once.
  - On a tick with anim_en=1, hold_cnt increments. When hold_cnt = HOLD_FRAMES-1 it wraps to 0, and frame_sel advances modulo NUM_FRAMES, from NUM_FRAMES-1 back to 0.
  - With anim_en=0, hold_cnt and frame_sel hold. The vsync history still updates.
  - frame_sel changes only on a tick, so there is no mid-frame tearing.
  - frame_sel feeds address generation directly in the same cycle.

Decomposition:
- sprite_pkg holds:
  - constants SCREEN_W=640, SCREEN_H=480, TRANSPARENT_IDX=4'h0;
  - pixel-coordinate typedef coord_t (logic [9:0]);
  - typedef pal_idx_t (logic [3:0]).
- One sub-module, anim_frame_seq, contains the vsync edge detect, hold counter and frame_sel, parameterised by NUM_FRAMES and HOLD_FRAMES. Address generation and the pipeline live in the top.

Test Plan:
- Reset: hold Reset 3 cycles with arbitrary inputs -> rom_addr=0, pix_index=0, pix_hit=0, pix_active=0, frame_sel=0; outputs stay 0 for 3 cycles after release until the pipeline fills.
- Basic hit: sprite (100,50), DrawX=100, DrawY=50, active_in=1, ROM model returns 4'h2 -> rom_addr=0 at N+1; pix_index=2, pix_hit=1, pix_active=1 at N+3. Then DrawX=131, DrawY=81 -> rom_addr=1023.
- Miss and transparency: DrawX=99 -> rom_addr=0, pix_hit=0, pix_index=0. DrawX=110 inside the sprite with rom_q=0 -> pix_hit=0, pix_index=0. active_in=0 inside the sprite -> pix_hit=0, pix_active=0.
- Clipping: sprite_x=620, sprite_y=0, DrawY=0, DrawX=639 -> hit, rom_addr=19. DrawX=0 -> no hit. sprite_x=700 -> never hits across a full line sweep.
- Animation: anim_en=1, 8 vsync falling edges -> frame_sel=1, and sprite (100,50) pixel (100,50) gives rom_addr=1024. After 24 edges -> frame_sel=0. vsync held low 100 cycles counts as one tick. anim_en=0 for 16 edges -> frame_sel unchanged.
- Reset mid-operation: assert Reset at frame_sel=2 with hold_cnt=5 during a hit stream -> all outputs 0 the next cycle. After release, frame_sel stays 0 for 7 ticks and advances to 1 on the 8th.
